// File: rtl/bcd_timer_ud.sv
// bcd_timer_ud: BCD mm:ss timer with an internal one-second prescaler.
// Counts down from a preset to zero, or up from zero to the preset. Supports
// start/stop, auto-reload at the terminal value and a one-cycle expiry pulse.
module bcd_timer_ud #(
  parameter int MIN_DIGITS = 2,
  parameter int TICK_DIV   = 1000
) (
  input  logic                    c1khz,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    up,
  input  logic                    autoreload,
  input  logic [4*MIN_DIGITS-1:0] pmin,
  input  logic [7:0]              psec,
  output logic [4*MIN_DIGITS-1:0] min,
  output logic [7:0]              sec,
  output logic                    running,
  output logic                    zero,
  output logic                    expired
);

  localparam int MW = 4*MIN_DIGITS;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(TICK_DIV-1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   min_q, min_d;
  logic [7:0]      sec_q, sec_d;
  logic [PW-1:0]   psc_q, psc_d;
  logic [MW-1:0]   pmin_q, pmin_d;   // clamped preset P (also the up-mode target T)
  logic [7:0]      psec_q, psec_d;
  logic            up_q, up_d;
  logic            ar_q, ar_d;
  logic            rld_q, rld_d;     // next step reloads instead of counting
  logic            exp_q, exp_d;

  logic [MW-1:0]   pmin_cl;
  logic [7:0]      psec_cl;
  logic [MW-1:0]   nmin;
  logic [7:0]      nsec;
  logic            cy;
  logic            term, nterm;

  // Clamp preset digits into valid BCD / seconds range
  always_comb begin
    pmin_cl = pmin;
    for (int i = 0; i < MIN_DIGITS; i++)
      if (pmin[4*i +: 4] > 4'd9) pmin_cl[4*i +: 4] = 4'd9;
    psec_cl[3:0] = (psec[3:0] > 4'd9) ? 4'd9 : psec[3:0];
    psec_cl[7:4] = (psec[7:4] > 4'd5) ? 4'd5 : psec[7:4];
  end

  // One BCD step of the current value with ripple carry/borrow
  always_comb begin
    nmin = min_q;
    nsec = sec_q;
    cy   = 1'b1;
    if (up_q) begin
      if (sec_q[3:0] == 4'd9) nsec[3:0] = 4'd0;
      else begin nsec[3:0] = sec_q[3:0] + 4'd1; cy = 1'b0; end
      if (cy) begin
        if (sec_q[7:4] == 4'd5) nsec[7:4] = 4'd0;
        else begin nsec[7:4] = sec_q[7:4] + 4'd1; cy = 1'b0; end
      end
      for (int i = 0; i < MIN_DIGITS; i++)
        if (cy) begin
          if (min_q[4*i +: 4] == 4'd9) nmin[4*i +: 4] = 4'd0;
          else begin nmin[4*i +: 4] = min_q[4*i +: 4] + 4'd1; cy = 1'b0; end
        end
    end else begin
      if (sec_q[3:0] == 4'd0) nsec[3:0] = 4'd9;
      else begin nsec[3:0] = sec_q[3:0] - 4'd1; cy = 1'b0; end
      if (cy) begin
        if (sec_q[7:4] == 4'd0) nsec[7:4] = 4'd5;
        else begin nsec[7:4] = sec_q[7:4] - 4'd1; cy = 1'b0; end
      end
      for (int i = 0; i < MIN_DIGITS; i++)
        if (cy) begin
          if (min_q[4*i +: 4] == 4'd0) nmin[4*i +: 4] = 4'd9;
          else begin nmin[4*i +: 4] = min_q[4*i +: 4] - 4'd1; cy = 1'b0; end
        end
    end
  end

  // Terminal detection for the current and the stepped value
  always_comb begin
    if (up_q) begin
      term  = (min_q == pmin_q) && (sec_q == psec_q);
      nterm = (nmin  == pmin_q) && (nsec  == psec_q);
    end else begin
      term  = (min_q == '0) && (sec_q == '0);
      nterm = (nmin  == '0) && (nsec  == '0);
    end
  end

  // Next-state: load > stop > start > prescaler step
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    psc_d   = psc_q;
    pmin_d  = pmin_q;
    psec_d  = psec_q;
    up_d    = up_q;
    ar_d    = ar_q;
    rld_d   = rld_q;
    exp_d   = 1'b0;
    if (load) begin
      pmin_d  = pmin_cl;
      psec_d  = psec_cl;
      up_d    = up;
      ar_d    = autoreload;
      psc_d   = '0;
      rld_d   = 1'b0;
      state_d = S_IDLE;
      if (up) begin
        min_d = '0;
        sec_d = '0;
      end else begin
        min_d = pmin_cl;
        sec_d = psec_cl;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          // prescaler is kept so a resume finishes the partial second
          if (!stop && start && !term) state_d = S_RUN;
        end
        S_RUN: begin
          if (stop) begin
            state_d = S_IDLE;
          end else if (psc_q == PSC_LAST) begin
            psc_d = '0;
            if (rld_q) begin
              rld_d = 1'b0;
              min_d = up_q ? '0 : pmin_q;
              sec_d = up_q ? '0 : psec_q;
            end else begin
              min_d = nmin;
              sec_d = nsec;
              if (nterm) begin
                exp_d = 1'b1;
                if (ar_q) rld_d   = 1'b1;
                else      state_d = S_DONE;
              end
            end
          end else begin
            psc_d = psc_q + PW'(1);
          end
        end
        default: ;  // DONE waits for load or rst
      endcase
    end
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge c1khz) begin
    if (rst) begin
      state_q <= S_IDLE;
      min_q   <= '0;
      sec_q   <= '0;
      psc_q   <= '0;
      pmin_q  <= '0;
      psec_q  <= '0;
      up_q    <= 1'b0;
      ar_q    <= 1'b0;
      rld_q   <= 1'b0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      psc_q   <= psc_d;
      pmin_q  <= pmin_d;
      psec_q  <= psec_d;
      up_q    <= up_d;
      ar_q    <= ar_d;
      rld_q   <= rld_d;
      exp_q   <= exp_d;
    end
  end

  assign min     = min_q;
  assign sec     = sec_q;
  assign running = (state_q == S_RUN);
  assign zero    = (min_q == '0) && (sec_q == '0);
  assign expired = exp_q;

endmodule

// File: tb/tb_bcd_timer_ud.sv
// Scoreboard bench for bcd_timer_ud (TICK_DIV=4, MIN_DIGITS=2).
// Stimulus pushes expected outputs tagged with the posedge count at which they
// must hold; a monitor checks them on the following falling edge.
module tb_bcd_timer_ud;

  logic       c1khz = 1'b0;
  logic       rst = 1'b1, load = 1'b0, start = 1'b0, stop = 1'b0;
  logic       up = 1'b0, autoreload = 1'b0;
  logic [7:0] pmin = '0, psec = '0;
  logic [7:0] min, sec;
  logic       running, zero, expired;

  bcd_timer_ud #(.MIN_DIGITS(2), .TICK_DIV(4)) dut (
    .c1khz(c1khz), .rst(rst), .load(load), .start(start), .stop(stop),
    .up(up), .autoreload(autoreload), .pmin(pmin), .psec(psec),
    .min(min), .sec(sec), .running(running), .zero(zero), .expired(expired)
  );

  always #5 c1khz = ~c1khz;

  typedef struct {
    int         cyc;
    logic [7:0] mn;
    logic [7:0] sc;
    logic       r, z, e;
  } exp_t;

  exp_t  q[$];
  string tagq[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  always @(posedge c1khz) cyc <= cyc + 1;

  // Monitor: compare the head entry when its cycle comes up
  always @(negedge c1khz) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL %s: expectation for cycle %0d was skipped (now %0d)", tagq[0], q[0].cyc, cyc);
      void'(q.pop_front()); void'(tagq.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      checks++;
      if (min !== q[0].mn || sec !== q[0].sc || running !== q[0].r ||
          zero !== q[0].z || expired !== q[0].e) begin
        errors++;
        $display("FAIL %s @%0d: got %h:%h run=%b zero=%b exp=%b, want %h:%h run=%b zero=%b exp=%b",
                 tagq[0], cyc, min, sec, running, zero, expired,
                 q[0].mn, q[0].sc, q[0].r, q[0].z, q[0].e);
      end
      void'(q.pop_front()); void'(tagq.pop_front());
    end
  end

  task automatic ex(input int k, input logic [7:0] mn, input logic [7:0] sc,
                    input logic r, input logic z, input logic e, input string t);
    exp_t x;
    x.cyc = cyc + k; x.mn = mn; x.sc = sc; x.r = r; x.z = z; x.e = e;
    q.push_back(x);
    tagq.push_back(t);
  endtask

  task automatic go(input int n);
    repeat (n) @(negedge c1khz);
  endtask

  task automatic do_load(input logic [7:0] pm, input logic [7:0] ps,
                         input logic u, input logic ar);
    load = 1'b1; pmin = pm; psec = ps; up = u; autoreload = ar;
  endtask

  initial begin
    go(2);
    ex(1, 8'h00, 8'h00, 0, 1, 0, "reset");
    go(1);
    rst = 1'b0;
    go(1);

    // down 01:00, full run to expiry
    do_load(8'h01, 8'h00, 0, 0);
    ex(1, 8'h01, 8'h00, 0, 0, 0, "load_dn");
    go(1); load = 1'b0; start = 1'b1;
    ex(1, 8'h01, 8'h00, 1, 0, 0, "start_dn");
    go(1); start = 1'b0;
    ex(3,   8'h01, 8'h00, 1, 0, 0, "pre_step");
    ex(4,   8'h00, 8'h59, 1, 0, 0, "step1_59");
    ex(40,  8'h00, 8'h50, 1, 0, 0, "step10_50");
    ex(239, 8'h00, 8'h01, 1, 0, 0, "pre_expire");
    ex(240, 8'h00, 8'h00, 0, 1, 1, "expire_dn");
    ex(241, 8'h00, 8'h00, 0, 1, 0, "expire_1cyc");
    go(242); start = 1'b1;
    ex(1, 8'h00, 8'h00, 0, 1, 0, "done_ign_start");
    ex(6, 8'h00, 8'h00, 0, 1, 0, "done_hold");
    go(6); start = 1'b0;

    // up mode to 00:12
    do_load(8'h00, 8'h12, 1, 0);
    ex(1, 8'h00, 8'h00, 0, 1, 0, "load_up");
    go(1); load = 1'b0; up = 1'b0; start = 1'b1;
    ex(1, 8'h00, 8'h00, 1, 1, 0, "start_up");
    go(1); start = 1'b0;
    ex(4,  8'h00, 8'h01, 1, 0, 0, "up_01");
    ex(36, 8'h00, 8'h09, 1, 0, 0, "up_09");
    ex(40, 8'h00, 8'h10, 1, 0, 0, "up_carry_10");
    ex(48, 8'h00, 8'h12, 0, 0, 1, "up_expire");
    ex(49, 8'h00, 8'h12, 0, 0, 0, "up_exp_1cyc");
    ex(60, 8'h00, 8'h12, 0, 0, 0, "up_hold");
    go(61);

    // down 00:02 with auto-reload
    do_load(8'h00, 8'h02, 0, 1);
    ex(1, 8'h00, 8'h02, 0, 0, 0, "load_ar");
    go(1); load = 1'b0; autoreload = 1'b0; start = 1'b1;
    go(1); start = 1'b0;
    ex(4,  8'h00, 8'h01, 1, 0, 0, "ar_01");
    ex(8,  8'h00, 8'h00, 1, 1, 1, "ar_exp1");
    ex(9,  8'h00, 8'h00, 1, 1, 0, "ar_exp1_end");
    ex(12, 8'h00, 8'h02, 1, 0, 0, "ar_reload");
    ex(16, 8'h00, 8'h01, 1, 0, 0, "ar_01b");
    ex(20, 8'h00, 8'h00, 1, 1, 1, "ar_exp2");
    ex(21, 8'h00, 8'h00, 1, 1, 0, "ar_exp2_end");
    go(21);

    // clamping, also aborts the auto-reload run
    do_load(8'hA7, 8'h9C, 0, 0);
    ex(1, 8'h97, 8'h59, 0, 0, 0, "clamp");
    go(1); load = 1'b0;

    // pause / resume / abort / reset
    do_load(8'h00, 8'h05, 0, 0);
    go(1); load = 1'b0; start = 1'b1;
    go(1); start = 1'b0;
    go(2); stop = 1'b1;
    ex(1, 8'h00, 8'h05, 0, 0, 0, "stop");
    go(1); stop = 1'b0;
    ex(10, 8'h00, 8'h05, 0, 0, 0, "pause_hold");
    go(10); start = 1'b1;
    ex(1, 8'h00, 8'h05, 1, 0, 0, "resume");
    go(1); start = 1'b0;
    ex(1, 8'h00, 8'h05, 1, 0, 0, "resume_partial");
    ex(2, 8'h00, 8'h04, 1, 0, 0, "resume_step");
    go(3);
    do_load(8'h00, 8'h30, 0, 0);
    ex(1, 8'h00, 8'h30, 0, 0, 0, "load_abort");
    go(1); load = 1'b0;
    ex(3, 8'h00, 8'h30, 0, 0, 0, "abort_idle");
    go(3); start = 1'b1;
    ex(1, 8'h00, 8'h30, 1, 0, 0, "run_before_rst");
    go(1); start = 1'b0;
    go(2); rst = 1'b1;
    ex(1, 8'h00, 8'h00, 0, 1, 0, "rst_mid");
    go(1); rst = 1'b0;

    // zero preset: start ignored in both modes
    do_load(8'h00, 8'h00, 0, 0);
    ex(1, 8'h00, 8'h00, 0, 1, 0, "load_zero_dn");
    go(1); load = 1'b0; start = 1'b1;
    ex(1, 8'h00, 8'h00, 0, 1, 0, "zero_dn_start");
    ex(8, 8'h00, 8'h00, 0, 1, 0, "zero_dn_hold");
    go(8); start = 1'b0;
    do_load(8'h00, 8'h00, 1, 0);
    go(1); load = 1'b0; up = 1'b0; start = 1'b1;
    ex(1, 8'h00, 8'h00, 0, 1, 0, "zero_up_start");
    ex(8, 8'h00, 8'h00, 0, 1, 0, "zero_up_hold");
    go(8); start = 1'b0;

    // simultaneous start and stop: stop wins
    do_load(8'h00, 8'h03, 0, 0);
    go(1); load = 1'b0; start = 1'b1; stop = 1'b1;
    ex(1, 8'h00, 8'h03, 0, 0, 0, "start_stop");
    ex(6, 8'h00, 8'h03, 0, 0, 0, "start_stop_hold");
    go(6); start = 1'b0; stop = 1'b0;

    for (int i = 0; i < 200 && q.size() > 0; i++) go(1);
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d expectations still pending, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
